// File: rtl/half_adder_core_pkg.sv
// Shared constants and helpers for the registered multi-lane half adder.
package half_adder_core_pkg;

    localparam int DEFAULT_WIDTH = 1;
    localparam int MAX_WIDTH     = 64;

    // Bits needed to hold a lane count from 0 to width inclusive.
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/half_adder_cell.sv
// Combinational single-bit half adder: one lane of half_adder_core.
module half_adder_cell (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/half_adder_core.sv
// Registered multi-lane half adder with one-cycle valid-qualified latency.
// Optional registered carry popcount enabled by HALF_ADDER_CORE_CARRY_COUNT_EN.
module half_adder_core
    import half_adder_core_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
`ifdef HALF_ADDER_CORE_CARRY_COUNT_EN
    ,
    output logic [count_width(WIDTH)-1:0] carry_count
`endif
);

    logic [WIDTH-1:0] sum_p0;
    logic [WIDTH-1:0] carry_p0;
    logic [WIDTH-1:0] sum_p1;
    logic [WIDTH-1:0] carry_p1;
    logic             vld_p1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_adder_cell u_cell (
            .a     (a[i]),
            .b     (b[i]),
            .sum   (sum_p0[i]),
            .carry (carry_p0[i])
        );
    end

    // Stage p0 -> p1: lane results load only when qualified, so idle inputs never reach the flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            sum_p1   <= '0;
            carry_p1 <= '0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                sum_p1   <= sum_p0;
                carry_p1 <= carry_p0;
            end
        end
    end

    assign out_valid = vld_p1;
    assign sum       = sum_p1;
    assign carry     = carry_p1;

`ifdef HALF_ADDER_CORE_CARRY_COUNT_EN
    localparam int CW = count_width(WIDTH);

    logic [CW-1:0] count_p1;

    function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + CW'(v[i]);
        end
        return cnt;
    endfunction

    // Stage p0 -> p1: count tracks the carry register under the same load rules.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_p1 <= '0;
        end else if (in_valid) begin
            count_p1 <= popcount(carry_p0);
        end
    end

    assign carry_count = count_p1;
`endif

endmodule

// File: tb/tb_half_adder_core.sv
// Randomized self-checking bench for half_adder_core at WIDTH=1 and WIDTH=8.
module tb_half_adder_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       v1, v8;
    logic [0:0] a1, b1;
    logic [7:0] a8, b8;
    logic       ov1, ov8;
    logic [0:0] s1, c1;
    logic [7:0] s8, c8;
`ifdef HALF_ADDER_CORE_CARRY_COUNT_EN
    logic [0:0] cc1;
    logic [3:0] cc8;
`endif

    // Reference state
    logic       e_v1, e_v8;
    logic [7:0] e_s1, e_c1, e_s8, e_c8;
    int         e_n1, e_n8;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    half_adder_core #(.WIDTH(1)) u_w1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (v1),
        .a           (a1),
        .b           (b1),
        .out_valid   (ov1),
        .sum         (s1),
        .carry       (c1)
`ifdef HALF_ADDER_CORE_CARRY_COUNT_EN
        ,
        .carry_count (cc1)
`endif
    );

    half_adder_core #(.WIDTH(8)) u_w8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (v8),
        .a           (a8),
        .b           (b8),
        .out_valid   (ov8),
        .sum         (s8),
        .carry       (c8)
`ifdef HALF_ADDER_CORE_CARRY_COUNT_EN
        ,
        .carry_count (cc8)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Each lane is an independent 2-bit addition a[i]+b[i]: bit 0 is sum, bit 1 is carry.
    task automatic lane_add(input logic [7:0] x, input logic [7:0] y, input int lanes,
                            output logic [7:0] s, output logic [7:0] c, output int n);
        s = '0;
        c = '0;
        n = 0;
        for (int i = 0; i < lanes; i++) begin
            int t;
            t = int'(x[i]) + int'(y[i]);
            s[i] = (t == 1);
            c[i] = (t == 2);
            if (t == 2) n++;
        end
    endtask

    // Advance one clock, update the model from the inputs sampled there, and compare.
    task automatic step(input string tag);
        @(posedge clk);
        if (!rst_n) begin
            e_v1 = 1'b0; e_s1 = '0; e_c1 = '0; e_n1 = 0;
            e_v8 = 1'b0; e_s8 = '0; e_c8 = '0; e_n8 = 0;
        end else begin
            e_v1 = v1;
            e_v8 = v8;
            if (v1) lane_add({7'd0, a1}, {7'd0, b1}, 1, e_s1, e_c1, e_n1);
            if (v8) lane_add(a8, b8, 8, e_s8, e_c8, e_n8);
        end
        #1;
        check({tag, ".w1_valid"}, 64'(ov1), 64'(e_v1));
        check({tag, ".w1_sum"},   64'(s1),  64'(e_s1[0]));
        check({tag, ".w1_carry"}, 64'(c1),  64'(e_c1[0]));
        check({tag, ".w8_valid"}, 64'(ov8), 64'(e_v8));
        check({tag, ".w8_sum"},   64'(s8),  64'(e_s8));
        check({tag, ".w8_carry"}, 64'(c8),  64'(e_c8));
`ifdef HALF_ADDER_CORE_CARRY_COUNT_EN
        check({tag, ".w1_count"}, 64'(cc1), 64'(e_n1));
        check({tag, ".w8_count"}, 64'(cc8), 64'(e_n8));
`endif
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
        v8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
        e_v1 = 1'b0; e_s1 = '0; e_c1 = '0; e_n1 = 0;
        e_v8 = 1'b0; e_s8 = '0; e_c8 = '0; e_n8 = 0;
        @(negedge clk);

        // Reset held for two edges with valid ones on the inputs
        for (int k = 0; k < 2; k++) begin
            step("reset");
            check("reset_w1_out", {62'd0, s1, c1}, 64'd0);
            check("reset_w8_valid", 64'(ov8), 64'd0);
        end
        rst_n = 1'b1;
        step("reset_release");
        check("release_w1_pair", {62'd0, c1, s1}, 64'd2);

        // WIDTH=1 exhaustive truth table, back to back
        for (int k = 0; k < 4; k++) begin
            logic [1:0] ab;
            ab = 2'(k);
            a1 = ab[1];
            b1 = ab[0];
            step("truth");
            check("truth_pair", {62'd0, c1, s1}, 64'(ab[1] + ab[0]));
        end

        // Hold behaviour while in_valid is low
        a1 = 1'b1; b1 = 1'b0; v1 = 1'b1;
        step("hold_load");
        v1 = 1'b0; a1 = 1'b1; b1 = 1'b1;
        step("hold_idle");
        check("hold_sum", 64'(s1), 64'd1);
        check("hold_carry", 64'(c1), 64'd0);
        check("hold_valid", 64'(ov1), 64'd0);

        // Fixed WIDTH=8 pattern
        v8 = 1'b1; a8 = 8'hF0; b8 = 8'hAA;
        step("f0aa");
        check("f0aa_sum", 64'(s8), 64'h5A);
        check("f0aa_carry", 64'(c8), 64'hA0);
`ifdef HALF_ADDER_CORE_CARRY_COUNT_EN
        check("f0aa_count", 64'(cc8), 64'd2);
`endif

        // Random stream with occasional single-edge reset pulses mid-stream
        for (int k = 0; k < 1000; k++) begin
            v1 = 1'($urandom_range(0, 3) != 0);
            v8 = 1'($urandom_range(0, 3) != 0);
            a1 = 1'($urandom);
            b1 = 1'($urandom);
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            rst_n = !(k == 300 || k == 700 || $urandom_range(0, 99) == 0);
            if (k == 300) begin
                v8 = 1'b1;
                v1 = 1'b1;
            end
            step("random");
            if (k == 300) check("midreset_w8_out", {47'd0, ov8, s8, c8}, 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
